// File: rtl/pe_stream_ctrl.sv
// pe_stream_ctrl: sequences one processing element through a streamed job.
// It preloads a weight, forwards N_SAMPLES activation/bias beats with a
// valid/ready handshake, then captures one PE result per accepted beat.
// The controller does no arithmetic on the data. It only routes values to the
// PE and times the capture of pe_out_i.
module pe_stream_ctrl #(
    parameter int N_SAMPLES = 4              // beats per job, legal 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] weight,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic [7:0] in_bias,
    output logic       in_ready,
    output logic [7:0] pe_in,
    output logic [7:0] pe_filter,
    output logic [1:0] mode_o,
    output logic       activate,
    input  logic [7:0] pe_out_i,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_FIN
    } state_t;

    // PE mode encodings
    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_SAVE   = 2'd1;
    localparam logic [1:0] MODE_SA     = 2'd2;
    localparam logic [1:0] MODE_INIT   = 2'd3;

    // Count value held while the final beat of a job is accepted
    localparam logic [7:0] LAST_BEAT = 8'(N_SAMPLES - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] beat_cnt;
    logic [7:0] weight_r;
    logic       accept;
    logic       last_beat;
    logic       job_start;
    logic       cap_pending;  // a beat was accepted last cycle. Its result shows up on pe_out_i now.

    // A beat transfers only while streaming and upstream offers one.
    assign accept    = (state == S_STREAM) && in_valid;
    assign last_beat = accept && (beat_cnt == LAST_BEAT);
    // start is looked at only in IDLE. A start seen while busy has no effect.
    assign job_start = (state == S_IDLE) && start;

    // State register
    // NOTE: every clocked block uses non-blocking (<=) assignments. All
    // registers then update together from values sampled before the edge,
    // whatever order the blocks are written in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    // NOTE: state_nx gets its default first, so no path through the case
    // leaves it unassigned. That keeps synthesis from inferring a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (start) state_nx = S_LOAD;
            S_LOAD:   state_nx = S_STREAM;
            S_STREAM: if (last_beat) state_nx = S_DRAIN;
            S_DRAIN:  state_nx = S_FIN;
            S_FIN:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // PE-facing outputs, decoded from state, the latched weight and the current beat
    always_comb begin
        mode_o    = MODE_INIT;
        activate  = 1'b0;
        in_ready  = 1'b0;
        pe_in     = 8'd0;
        pe_filter = 8'd0;
        unique case (state)
            S_IDLE: begin
                mode_o = MODE_INIT;
            end
            S_LOAD: begin
                // The PE stores its weight from the filter input in save mode.
                mode_o    = MODE_SAVE;
                pe_filter = weight_r;
            end
            S_STREAM: begin
                mode_o   = MODE_SA;
                in_ready = 1'b1;
                if (in_valid) begin
                    activate  = 1'b1;
                    pe_in     = in_data;
                    pe_filter = in_bias;
                end
            end
            S_DRAIN: begin
                // Keep the PE in systolic mode while the last result settles.
                mode_o = MODE_SA;
            end
            S_FIN: begin
                mode_o = MODE_INIT;
            end
            default: begin
                mode_o = MODE_INIT;
            end
        endcase
    end

    // Job bookkeeping: weight capture on an accepted start, beat counting while streaming
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_r <= 8'd0;
            beat_cnt <= 8'd0;
        end else if (job_start) begin
            weight_r <= weight;
            beat_cnt <= 8'd0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

    // Result capture: mark the accepted beat, then sample pe_out_i one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_pending <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= 8'd0;
        end else begin
            cap_pending <= accept;
            res_valid   <= cap_pending;
            // res_data keeps the last result between strobes.
            if (cap_pending) begin
                res_data <= pe_out_i;
            end
        end
    end

    // Registered status: busy outside IDLE, done for the single FIN cycle.
    // The last result is captured on the DRAIN->FIN edge, so done lines up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nx != S_IDLE);
            done <= (state_nx == S_FIN);
        end
    end

endmodule

// File: tb/tb_pe_stream_ctrl.sv
// tb_pe_stream_ctrl: directed and randomized jobs for pe_stream_ctrl.
// A small behavioural PE drives pe_out_i. Expected results come from the
// arithmetic rule ((data*weight) mod 256 + bias) mod 256. They are kept in a
// queue in acceptance order, each with its acceptance cycle and a last-beat flag.
module tb_pe_stream_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] weight;
    logic       in_valid;
    logic [7:0] in_data;
    logic [7:0] in_bias;
    logic       in_ready;
    logic [7:0] pe_in;
    logic [7:0] pe_filter;
    logic [1:0] mode_o;
    logic       activate;
    logic [7:0] pe_out_i;
    logic       res_valid;
    logic [7:0] res_data;
    logic       busy;
    logic       done;

    pe_stream_ctrl #(.N_SAMPLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .weight    (weight),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_bias   (in_bias),
        .in_ready  (in_ready),
        .pe_in     (pe_in),
        .pe_filter (pe_filter),
        .mode_o    (mode_o),
        .activate  (activate),
        .pe_out_i  (pe_out_i),
        .res_valid (res_valid),
        .res_data  (res_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural PE: save mode stores the weight. An activated cycle
    // registers in*w + filter.
    logic [7:0] pe_w;
    logic [7:0] pe_sum;
    always @(posedge clk) begin
        if (mode_o == 2'd1) pe_w <= pe_filter;
        if (activate) pe_sum <= 8'(pe_in * pe_w + pe_filter);
    end
    assign pe_out_i = pe_sum;

    // Reference model state
    typedef struct {
        int val;
        int cyc;
        bit last;
    } exp_t;

    exp_t       q[$];
    logic [7:0] model_w;
    int         model_beats;
    int         cyc = 0;
    int         done_cnt = 0;
    int         last_res = 0;

    always @(posedge clk) cyc++;

    // Monitor: sampled on the falling edge, between active edges
    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid) begin
                check("res_expected", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("res_data", 32'(res_data), 32'(e.val));
                    check("res_latency", 32'(cyc - e.cyc), 32'd2);
                    check("done_align", 32'(done), 32'(e.last));
                    last_res = e.val;
                end
            end else begin
                check("done_quiet", 32'(done), 32'd0);
            end
            if (done) done_cnt++;
            if (in_ready && in_valid) begin
                exp_t e;
                model_beats++;
                e.val  = ((int'(in_data) * int'(model_w)) % 256 + int'(in_bias)) % 256;
                e.cyc  = cyc;
                e.last = (model_beats == N);
                q.push_back(e);
            end
        end
    end

    logic [7:0] d[N];
    logic [7:0] b[N];
    int         gaps[N];

    task automatic set_job(input logic [7:0] d0, d1, d2, d3, input logic [7:0] bias);
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int i = 0; i < N; i++) begin
            b[i]    = bias;
            gaps[i] = 0;
        end
    endtask

    task automatic do_job(input logic [7:0] w, input bit spurious);
        int dc0;
        dc0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; weight = w; model_w = w; model_beats = 0;
        @(posedge clk); #1;
        start = 1'b0; weight = 8'($urandom);
        #1;
        check("load_mode", 32'(mode_o), 32'd1);
        check("load_filter", 32'(pe_filter), 32'(w));
        check("load_act", 32'(activate), 32'd0);
        check("load_busy", 32'(busy), 32'd1);
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                @(posedge clk); #1;
                in_valid = 1'b0; in_data = 8'($urandom); in_bias = 8'($urandom);
                #1;
                check("gap_act", 32'(activate), 32'd0);
                check("gap_pe_in", 32'(pe_in), 32'd0);
                check("gap_mode", 32'(mode_o), 32'd2);
            end
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = d[i]; in_bias = b[i];
            if (spurious && i == 1) begin
                start = 1'b1; weight = ~w;
            end
            #1;
            check("beat_act", 32'(activate), 32'd1);
            check("beat_pe_in", 32'(pe_in), 32'(d[i]));
            check("beat_filter", 32'(pe_filter), 32'(b[i]));
            check("beat_ready", 32'(in_ready), 32'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; start = 1'b0;
        #1;
        check("drain_mode", 32'(mode_o), 32'd2);
        check("drain_ready", 32'(in_ready), 32'd0);
        check("drain_act", 32'(activate), 32'd0);
        @(posedge clk); #2;
        check("fin_mode", 32'(mode_o), 32'd3);
        check("fin_done", 32'(done), 32'd1);
        check("fin_busy", 32'(busy), 32'd1);
        @(posedge clk); #2;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("done_count", 32'(done_cnt - dc0), 32'd1);
        check("res_hold", 32'(res_data), 32'(last_res));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; weight = 8'd0;
        in_valid = 1'b0; in_data = 8'd0; in_bias = 8'd0;
        model_w = 8'd0; model_beats = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mode", 32'(mode_o), 32'd3);
        check("rst_act", 32'(activate), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        // Basic job: 13,16,19,22
        set_job(8'd1, 8'd2, 8'd3, 8'd4, 8'd10);
        do_job(8'd3, 1'b0);
        check("basic_last", 32'(res_data), 32'd22);

        // Bubbles between beats 2 and 3
        set_job(8'd1, 8'd2, 8'd3, 8'd4, 8'd10);
        gaps[2] = 2;
        do_job(8'd3, 1'b0);
        check("bubble_last", 32'(res_data), 32'd22);

        // Wraparound: (400 mod 256) + 100 = 244
        set_job(8'd20, 8'd20, 8'd20, 8'd20, 8'd100);
        do_job(8'd20, 1'b0);
        check("wrap_res", 32'(res_data), 32'd244);

        // start while busy with a different weight is ignored
        set_job(8'd9, 8'd17, 8'd33, 8'd250, 8'd7);
        do_job(8'd7, 1'b1);

        // Reset in the middle of STREAM after two accepted beats
        begin
            int dc0;
            dc0 = done_cnt;
            @(posedge clk); #1;
            start = 1'b1; weight = 8'd9; model_w = 8'd9; model_beats = 0;
            @(posedge clk); #1;
            start = 1'b0;
            for (int i = 0; i < 2; i++) begin
                @(posedge clk); #1;
                in_valid = 1'b1; in_data = 8'(i + 11); in_bias = 8'd3;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            rst = 1'b1;
            q.delete();
            #1;
            check("midrst_mode", 32'(mode_o), 32'd3);
            check("midrst_ready", 32'(in_ready), 32'd0);
            check("midrst_busy", 32'(busy), 32'd0);
            check("midrst_res_valid", 32'(res_valid), 32'd0);
            repeat (2) @(posedge clk);
            #1;
            check("midrst_res_data", 32'(res_data), 32'd0);
            rst = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            check("midrst_no_done", 32'(done_cnt - dc0), 32'd0);
            check("midrst_idle", 32'(busy), 32'd0);
        end

        // Job after reset: weight 1, data 5, bias 0
        set_job(8'd5, 8'd5, 8'd5, 8'd5, 8'd0);
        do_job(8'd1, 1'b0);
        check("post_rst_res", 32'(res_data), 32'd5);

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            logic [7:0] w;
            w = 8'($urandom);
            for (int i = 0; i < N; i++) begin
                d[i]    = 8'($urandom);
                b[i]    = 8'($urandom);
                gaps[i] = int'($urandom_range(0, 2));
            end
            do_job(w, (j % 3) == 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_stream_ctrl.md
PE_STREAM_CTRL -- requirements
Module: pe_stream_ctrl

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 4, meaning the number of input beats streamed per job (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: job request; sampled only in IDLE.
REQ-005 SHALL have port weight, input, 8 bits: weight to preload into the PE; captured on an accepted start.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream beat valid.
REQ-007 SHALL have port in_data, input, 8 bits: activation for the beat.
REQ-008 SHALL have port in_bias, input, 8 bits: bias/partial sum for the beat.
REQ-009 SHALL have port in_ready, output, 1 bit: controller accepts a beat this cycle.
REQ-010 SHALL have port pe_in, output, 8 bits: PE activation input.
REQ-011 SHALL have port pe_filter, output, 8 bits: PE filter/bias input.
REQ-012 SHALL have port mode_o, output, 2 bits: PE mode (0 single, 1 save, 2 sa, 3 initial).
REQ-013 SHALL have port activate, output, 1 bit: PE sum-register update enable.
REQ-014 SHALL have port pe_out_i, input, 8 bits: PE result output.
REQ-015 SHALL have port res_valid, output, 1 bit: one-cycle result strobe.
REQ-016 SHALL have port res_data, output, 8 bits: captured PE result.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1 bit: one-cycle end-of-job pulse.

Function
REQ-019 SHALL implement the FSM states IDLE, LOAD, STREAM, DRAIN, FIN.
REQ-020 In IDLE: mode_o=3, activate=0, in_ready=0, pe_in=0, pe_filter=0; start=1 -> LOAD, weight latched into weight_r, beat counter cleared.
REQ-021 In LOAD (exactly 1 cycle): mode_o=1, pe_filter=weight_r, pe_in=0, activate=0; -> STREAM.
REQ-022 In STREAM: mode_o=2, in_ready=1; a beat is accepted when in_valid=1; on an accepted beat pe_in=in_data, pe_filter=in_bias, activate=1, and the counter increments.
REQ-023 In STREAM with in_valid=0: activate=0, pe_in=0, pe_filter=0, mode_o stays 2, and no beat is counted.
REQ-024 Acceptance of beat N_SAMPLES SHALL move the FSM to DRAIN on the same edge.
REQ-025 In DRAIN (exactly 1 cycle): mode_o=2, activate=0, in_ready=0; -> FIN.
REQ-026 In FIN (exactly 1 cycle): mode_o=3, done=1; -> IDLE.
REQ-027 pe_in, pe_filter, mode_o, activate and in_ready SHALL be combinational functions of state, weight_r and the inputs. res_valid, res_data, done and busy SHALL be registered.
REQ-028 Result capture: a beat accepted in cycle t SHALL have pe_out_i sampled at the end of cycle t+1 into res_data, with res_valid=1 during cycle t+2 only.
REQ-029 Results SHALL be produced in acceptance order, exactly one per accepted beat.
REQ-030 The expected result is ((in_data*weight) mod 256 + in_bias) mod 256; the controller performs no arithmetic on the data.
REQ-031 The last res_valid of a job SHALL coincide with done.
REQ-032 start while busy=1 SHALL be ignored and SHALL NOT re-latch weight.
REQ-033 res_data SHALL hold its last value while res_valid=0.

Reset
REQ-034 On rst=1, at any time including mid-job, the block SHALL asynchronously enter IDLE and clear the counter, weight_r, the capture pipeline, res_data, res_valid, done and busy to 0; mode_o SHALL be 3.
REQ-035 No res_valid or done SHALL be produced for a job interrupted by reset.

Verification
REQ-036 Reset: assert rst for 2 cycles -> mode_o=3, activate=0, in_ready=0, res_valid=0, busy=0, done=0.
REQ-037 Basic: weight=3, beats (1,10),(2,10),(3,10),(4,10) on consecutive cycles -> res_data 13,16,19,22 each 2 cycles after its beat, done with the last result.
REQ-038 Bubbles: same job with in_valid low for 2 cycles between beats 2 and 3 -> activate=0 during the gaps, same four results in order, no extra res_valid.
REQ-039 Wrap: weight=20, in_data=20, in_bias=100 -> res_data=244.
REQ-040 Reset mid-STREAM after 2 accepted beats -> IDLE immediately, no further res_valid or done; a following job with weight=1, data 5, bias 0 -> all results equal 5.
REQ-041 start pulsed during STREAM with a different weight -> ignored; results use the original weight; exactly one done.
